// File: rtl/handshake_cmpi_arbiter.sv
// rtl/handshake_cmpi_arbiter.sv - round-robin shared equality comparator for elastic channels
module handshake_cmpi_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_TYPE = 32,
  parameter int TAG_WIDTH = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   lhs,
  input  logic [NUM_REQ-1:0]             lhs_valid,
  output logic [NUM_REQ-1:0]             lhs_ready,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   rhs,
  input  logic [NUM_REQ-1:0]             rhs_valid,
  output logic [NUM_REQ-1:0]             rhs_ready,
  output logic                           result,
  output logic [TAG_WIDTH-1:0]           result_tag,
  output logic                           result_valid,
  input  logic                           result_ready
);

  logic [TAG_WIDTH-1:0] rr_ptr;
  logic                 out_valid;
  logic                 can_load;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic                 grant_any;
  logic [TAG_WIDTH-1:0] grant_idx;
  logic [TAG_WIDTH-1:0] next_ptr;
  logic [DATA_TYPE-1:0] sel_lhs;
  logic [DATA_TYPE-1:0] sel_rhs;
  int                   idx;
  int                   nidx;

  // A channel joins only when both of its operands are present.
  assign eligible = lhs_valid & rhs_valid;
  // The output slot can take a new result if empty or being drained this cycle.
  assign can_load = !out_valid || result_ready;

  // Scan from rr_ptr with explicit modulo so non-power-of-2 counts never index past NUM_REQ-1.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    next_ptr  = '0;
    sel_lhs   = '0;
    sel_rhs   = '0;
    idx       = 0;
    nidx      = 0;
    if (!rst && can_load) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant_any && eligible[idx]) begin
          grant[idx] = 1'b1;
          grant_any  = 1'b1;
          grant_idx  = TAG_WIDTH'(idx);
          sel_lhs    = lhs[idx*DATA_TYPE +: DATA_TYPE];
          sel_rhs    = rhs[idx*DATA_TYPE +: DATA_TYPE];
          nidx       = (idx == NUM_REQ - 1) ? 0 : idx + 1;
          next_ptr   = TAG_WIDTH'(nidx);
        end
      end
    end
  end

  // Both operands of the granted channel are consumed together.
  assign lhs_ready    = grant;
  assign rhs_ready    = grant;
  assign result_valid = out_valid;

  // Output slot: load on grant (possibly while draining), otherwise drain on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      result     <= 1'b0;
      result_tag <= '0;
      rr_ptr     <= '0;
    end else if (grant_any) begin
      out_valid  <= 1'b1;
      result     <= (sel_lhs == sel_rhs);
      result_tag <= grant_idx;
      rr_ptr     <= next_ptr;
    end else if (out_valid && result_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_handshake_cmpi_arbiter.sv
// tb/tb_handshake_cmpi_arbiter.sv - scoreboard bench for two- and three-channel arbiters
module tb_handshake_cmpi_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic [63:0] lhs2, rhs2;
  logic [1:0]  lv2, rv2, lr2, rr2;
  logic        res2, rvld2, rrdy2;
  logic [0:0]  tag2;

  logic [95:0] lhs3, rhs3;
  logic [2:0]  lv3, rv3, lr3, rr3;
  logic        res3, rvld3, rrdy3;
  logic [1:0]  tag3;

  int checks = 0;
  int errors = 0;
  int m_rr [2];
  int sb [2][$];

  always #5 clk = ~clk;

  handshake_cmpi_arbiter #(.NUM_REQ(2), .DATA_TYPE(32), .TAG_WIDTH(1)) dut2 (
    .clk(clk), .rst(rst),
    .lhs(lhs2), .lhs_valid(lv2), .lhs_ready(lr2),
    .rhs(rhs2), .rhs_valid(rv2), .rhs_ready(rr2),
    .result(res2), .result_tag(tag2), .result_valid(rvld2), .result_ready(rrdy2)
  );

  handshake_cmpi_arbiter #(.NUM_REQ(3), .DATA_TYPE(32), .TAG_WIDTH(2)) dut3 (
    .clk(clk), .rst(rst),
    .lhs(lhs3), .lhs_valid(lv3), .lhs_ready(lr3),
    .rhs(rhs3), .rhs_valid(rv3), .rhs_ready(rr3),
    .result(res3), .result_tag(tag3), .result_valid(rvld3), .result_ready(rrdy3)
  );

  task automatic check_dut(input int d);
    int n, g, idx, e, tag;
    logic [31:0] l [3];
    logic [31:0] r [3];
    logic [2:0] lv, rv, lr, rr, er;
    logic res, vld, rdy;
    for (int i = 0; i < 3; i++) begin l[i] = '0; r[i] = '0; end
    if (d == 0) begin
      n = 2;
      for (int i = 0; i < 2; i++) begin l[i] = lhs2[i*32 +: 32]; r[i] = rhs2[i*32 +: 32]; end
      lv = {1'b0, lv2}; rv = {1'b0, rv2}; lr = {1'b0, lr2}; rr = {1'b0, rr2};
      res = res2; tag = int'(tag2); vld = rvld2; rdy = rrdy2;
    end else begin
      n = 3;
      for (int i = 0; i < 3; i++) begin l[i] = lhs3[i*32 +: 32]; r[i] = rhs3[i*32 +: 32]; end
      lv = lv3; rv = rv3; lr = lr3; rr = rr3;
      res = res3; tag = int'(tag3); vld = rvld3; rdy = rrdy3;
    end
    if (rst) begin
      sb[d].delete();
      m_rr[d] = 0;
    end
    g = -1;
    if (!rst && (sb[d].size() == 0 || rdy)) begin
      for (int k = 0; k < n; k++) begin
        idx = (m_rr[d] + k) % n;
        if (g < 0 && lv[idx] && rv[idx]) g = idx;
      end
    end
    er = (g >= 0) ? (3'b001 << g) : 3'b000;
    checks++;
    if (lr !== er || rr !== er) begin
      errors++;
      $display("FAIL ready dut%0d: lhs_ready=%b rhs_ready=%b expected %b", n, lr, rr, er);
    end
    checks++;
    if (vld !== (sb[d].size() != 0)) begin
      errors++;
      $display("FAIL result_valid dut%0d: got %b expected %0d", n, vld, sb[d].size() != 0);
    end
    if (sb[d].size() != 0) begin
      e = sb[d][0];
      checks++;
      if (tag != e / 2 || res !== ((e % 2) == 1)) begin
        errors++;
        $display("FAIL result dut%0d: tag=%0d result=%b expected tag=%0d result=%0d", n, tag, res, e / 2, e % 2);
      end
      if (rdy) void'(sb[d].pop_front());
    end
    if (g >= 0) begin
      sb[d].push_back(g * 2 + ((l[g] == r[g]) ? 1 : 0));
      m_rr[d] = (g + 1) % n;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    lhs2 = {32'h5, 32'h0}; rhs2 = {32'h5, 32'h0};
    lv2 = 2'b10; rv2 = 2'b10; rrdy2 = 1'b1;
    step();
    expect_bit("pre_reset_valid", rvld2, 1'b1);
    expect_bit("pre_reset_tag", tag2[0], 1'b1);
    lv2 = 2'b11; rv2 = 2'b11; rrdy2 = 1'b0;
    rst = 1'b1;
    #1;
    expect_bit("async_valid", rvld2, 1'b0);
    expect_bit("async_result", res2, 1'b0);
    expect_bit("async_tag", tag2[0], 1'b0);
    checks++;
    if (lr2 !== 2'b00 || rr2 !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: lhs_ready=%b rhs_ready=%b expected 00", lr2, rr2);
    end
    step();
    rst = 1'b0;
    lv2 = 2'b00; rv2 = 2'b00; rrdy2 = 1'b1;
    repeat (3) step();
    expect_bit("idle_valid", rvld2, 1'b0);
    expect_bit("idle_result", res2, 1'b0);
  endtask

  task automatic test_single();
    lhs2 = {32'h0000_002A, 32'h0}; rhs2 = {32'h0000_002A, 32'h0};
    lv2 = 2'b10; rv2 = 2'b10; rrdy2 = 1'b1;
    step();
    expect_bit("single_eq_result", res2, 1'b1);
    expect_bit("single_eq_tag", tag2[0], 1'b1);
    rhs2 = {32'h0000_002B, 32'h0};
    step();
    expect_bit("single_ne_result", res2, 1'b0);
    expect_bit("single_ne_tag", tag2[0], 1'b1);
    lv2 = 2'b00; rv2 = 2'b00;
    step();
  endtask

  task automatic test_round_robin();
    lv3 = 3'b111; rv3 = 3'b111; rrdy3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      lhs3 = {$urandom_range(3), $urandom_range(3), $urandom_range(3)};
      rhs3 = {$urandom_range(3), $urandom_range(3), $urandom_range(3)};
      step();
      checks++;
      if (rvld3 !== 1'b1 || tag3 !== 2'(k % 3)) begin
        errors++;
        $display("FAIL rr_sequence step %0d: valid=%b tag=%0d expected tag %0d", k, rvld3, tag3, k % 3);
      end
    end
    lv3 = 3'b000; rv3 = 3'b000;
    step();
  endtask

  task automatic test_partial_join();
    lhs2 = {32'h7, 32'h9}; rhs2 = {32'h7, 32'h9};
    lv2 = 2'b11; rv2 = 2'b10; rrdy2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      expect_bit("partial_ch0_ready", lr2[0], 1'b0);
      expect_bit("partial_ch1_tag", tag2[0], 1'b1);
    end
    rv2 = 2'b11;
    step();
    expect_bit("join_ch0_tag", tag2[0], 1'b0);
    lv2 = 2'b00; rv2 = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    lhs2 = {32'h1, 32'h3}; rhs2 = {32'h2, 32'h3};
    lv2 = 2'b01; rv2 = 2'b01; rrdy2 = 1'b1;
    step();
    rrdy2 = 1'b0; lv2 = 2'b11; rv2 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_bit("bp_result", res2, 1'b1);
      expect_bit("bp_tag", tag2[0], 1'b0);
      expect_bit("bp_ready", |{lr2, rr2}, 1'b0);
    end
    rrdy2 = 1'b1;
    step();
    expect_bit("bp_release_valid", rvld2, 1'b1);
    expect_bit("bp_release_tag", tag2[0], 1'b1);
    lv2 = 2'b00; rv2 = 2'b00;
    step();
  endtask

  task automatic test_wrap();
    lhs3 = {32'hFFFF_FFFF, 32'h0, 32'h1}; rhs3 = {32'hFFFF_FFFF, 32'h0, 32'h1};
    lv3 = 3'b100; rv3 = 3'b100; rrdy3 = 1'b1;
    step();
    checks++;
    if (tag3 !== 2'd2 || res3 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ch2: tag=%0d result=%b expected tag=2 result=1", tag3, res3);
    end
    lv3 = 3'b011; rv3 = 3'b011;
    step();
    checks++;
    if (tag3 !== 2'd0) begin
      errors++;
      $display("FAIL wrap_to_ch0: tag=%0d expected 0", tag3);
    end
    lv3 = 3'b000; rv3 = 3'b000;
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 1000; k++) begin
      lv2 = 2'($urandom); rv2 = 2'($urandom); rrdy2 = 1'($urandom);
      lhs2 = {$urandom_range(2), $urandom_range(2)};
      rhs2 = {$urandom_range(2), $urandom_range(2)};
      lv3 = 3'($urandom); rv3 = 3'($urandom); rrdy3 = ($urandom_range(3) != 0);
      lhs3 = {$urandom_range(2), $urandom_range(2), $urandom_range(2)};
      rhs3 = {$urandom_range(2), $urandom_range(2), $urandom_range(2)};
      step();
      checks++;
      if (rvld3 === 1'b1 && tag3 === 2'd3) begin
        errors++;
        $display("FAIL tag_range: tag=3 produced at random cycle %0d", k);
      end
    end
    lv2 = 2'b00; rv2 = 2'b00; rrdy2 = 1'b1;
    lv3 = 3'b000; rv3 = 3'b000; rrdy3 = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    rst = 1'b1;
    lhs2 = '0; rhs2 = '0; lv2 = '0; rv2 = '0; rrdy2 = 1'b1;
    lhs3 = '0; rhs3 = '0; lv3 = '0; rv3 = '0; rrdy3 = 1'b1;
    m_rr[0] = 0; m_rr[1] = 0;
    #1;
    repeat (2) step();
    rst = 1'b0;
    step();
    test_reset();
    test_single();
    test_round_robin();
    test_partial_join();
    test_backpressure();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_cmpi_arbiter.md
Name: handshake_cmpi_arbiter

Overview:
- Shares one equality comparator (lhs == rhs -> 1-bit result) between NUM_REQ independent elastic requester channels.
- Each channel presents an lhs/rhs operand pair with valid/ready handshakes. A round-robin arbiter picks one complete pair per cycle.
- The registered result leaves on a single tagged output channel.
- Sits between dataflow producers and a tag-demultiplexing consumer, replacing NUM_REQ separate comparator units.

Parameters:
- NUM_REQ, 2, number of requester channels (>= 2).
- DATA_TYPE, 32, operand width in bits.
- TAG_WIDTH, 1, width of the requester index; must equal max(1, ceil(log2(NUM_REQ))).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- lhs  input  NUM_REQ*DATA_TYPE  packed left operands; channel i occupies bits [i*DATA_TYPE +: DATA_TYPE].
- lhs_valid  input  NUM_REQ  per-channel lhs valid.
- lhs_ready  output  NUM_REQ  per-channel lhs ready.
- rhs  input  NUM_REQ*DATA_TYPE  packed right operands, same layout as lhs.
- rhs_valid  input  NUM_REQ  per-channel rhs valid.
- rhs_ready  output  NUM_REQ  per-channel rhs ready.
- result  output  1  comparison result: 1 if lhs == rhs, else 0.
- result_tag  output  TAG_WIDTH  index of the channel that produced result.
- result_valid  output  1  output register holds a result.
- result_ready  input  1  downstream accepts result.

Behaviour:
- Reset (async, rst=1): out_valid=0, result=0, result_tag=0, rr_ptr=0. All lhs_ready/rhs_ready are 0 while rst=1.
- A result pending when reset asserts mid-operation is discarded. No operands are consumed while rst=1.
- Eligibility: channel i is eligible when lhs_valid[i] & rhs_valid[i] (join semantics). A channel with only one operand valid is never granted and none of its operands are consumed.
- Output register is a 1-entry slot with implicit states EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = !out_valid | result_ready.
- Arbitration is combinational. If can_load, grant the first eligible channel scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ. At most one grant per cycle.
- Handshake: lhs_ready[i] = rhs_ready[i] = grant[i]. Both operands of the granted channel are consumed in the same cycle; all other readies are 0.
- Ready may depend on valid; valid never depends on ready.
- On a clock edge with a grant to i:
  - result <= (lhs_i == rhs_i), full DATA_TYPE unsigned bitwise equality.
  - result_tag <= i; out_valid <= 1; rr_ptr <= (i+1) mod NUM_REQ.
- On an edge with no grant:
  - If result_valid & result_ready, out_valid <= 0.
  - rr_ptr is unchanged.
- Simultaneous drain and load (FULL, result_ready=1, grant present): the old result is consumed and the new one loaded in the same edge. out_valid stays 1.
- Backpressure: while result_valid=1 & result_ready=0, result and result_tag are held stable, no grants occur, and all readies are 0.
- Latency: 1 cycle from operand acceptance to result_valid.
- Throughput: 1 result/cycle while result_ready=1.
- Fairness: a continuously eligible channel is granted within NUM_REQ grants.
- rr_ptr wrap-around: (NUM_REQ-1)+1 -> 0. TAG_WIDTH-wide arithmetic must not produce out-of-range indices for non-power-of-2 NUM_REQ.

Test Plan:
- Reset/idle: assert rst mid-result (result_valid=1, tag=1) -> result_valid=0, result=0, result_tag=0 immediately (async), all readies 0; after release with no valids, outputs stay 0.
- Single channel (NUM_REQ=2): ch1 lhs=0x0000_002A, rhs=0x0000_002A, result_ready=1 -> lhs_ready[1]=rhs_ready[1]=1 that cycle; next cycle result=1, result_tag=1, result_valid=1. Repeat with rhs=0x0000_002B -> result=0.
- Round-robin contention (NUM_REQ=3): all three channels continuously valid, result_ready=1 -> result_tag sequence 0,1,2,0,1,2 on consecutive cycles, one result per cycle.
- Partial join: ch0 lhs_valid=1, rhs_valid=0 for 5 cycles while ch1 is fully valid -> only ch1 is granted; lhs_ready[0] stays 0; ch0 is granted on the cycle its rhs_valid rises, provided rr_ptr reaches it.
- Backpressure: result_valid=1 with result=1, tag=0 and result_ready=0 for 4 cycles, both channels valid -> result/tag stable, all readies 0; on the cycle result_ready=1, ch1 is granted, and next cycle result_tag=1 with no bubble.
- Non-power-of-2 wrap (NUM_REQ=3, TAG_WIDTH=2): grant ch2 with lhs=0xFFFF_FFFF, rhs=0xFFFF_FFFF -> result=1, tag=2; rr_ptr wraps to 0, and tag value 3 is never produced over 1000 random cycles.
